// File: rtl/rv_pkg.sv
// Shared RV32I/M decode types and major-opcode constants.
package rv_pkg;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LUI, AUIPC, JAL, JALR,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
        NOP
    } alu_op_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} inst_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; R-format carries no immediate.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] inst,
    input  inst_fmt_t   fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (fmt)
            FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm = {inst[31:12], 12'd0};
            FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I(+M) decoder feeding a 2-entry in-order skid buffer; outputs come from the head entry.
module decode_stage
    import rv_pkg::*;
#(
    parameter int ENABLE_M = 0,
    parameter int PC_W     = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output alu_op_t         out_alu_op,
    output inst_fmt_t       out_fmt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_we,
    output logic [31:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    typedef struct packed {
        alu_op_t         op;
        inst_fmt_t       fmt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_we;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{op: NOP, fmt: FMT_R, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                       rd_we: 1'b0, imm: 32'd0, pc: '0, illegal: 1'b0};

    occ_t      state_reg;
    entry_t    head_reg, tail_reg, dec_entry;
    alu_op_t   dec_op;
    inst_fmt_t dec_fmt;
    logic      dec_legal, use_rs1, use_rs2;
    logic [31:0] dec_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        push, pop;

    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    always_comb begin
        dec_op    = NOP;
        dec_fmt   = FMT_R;
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (in_inst[6:0])
            OPC_OP: begin
                dec_fmt = FMT_R;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000: dec_op = ADD;
                        3'b001: dec_op = SLL;
                        3'b010: dec_op = SLT;
                        3'b011: dec_op = SLTU;
                        3'b100: dec_op = XOR;
                        3'b101: dec_op = SRL;
                        3'b110: dec_op = OR;
                        default: dec_op = AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_op = SUB;
                        dec_legal = 1'b1;
                    end else if (funct3 == 3'b101) begin
                        dec_op = SRA;
                        dec_legal = 1'b1;
                    end
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000: dec_op = MUL;
                        3'b001: dec_op = MULH;
                        3'b010: dec_op = MULHSU;
                        3'b011: dec_op = MULHU;
                        3'b100: dec_op = DIV;
                        3'b101: dec_op = DIVU;
                        3'b110: dec_op = REM;
                        default: dec_op = REMU;
                    endcase
                end
            end
            OPC_OPIMM: begin
                dec_fmt   = FMT_I;
                use_rs1   = 1'b1;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000: dec_op = ADDI;
                    3'b010: dec_op = SLTI;
                    3'b011: dec_op = SLTIU;
                    3'b100: dec_op = XORI;
                    3'b110: dec_op = ORI;
                    3'b111: dec_op = ANDI;
                    3'b001: begin
                        dec_op    = SLLI;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    default: begin
                        // imm[11:5] doubles as the shift-kind selector
                        dec_op    = (funct7 == 7'b0100000) ? SRAI : SRLI;
                        dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_fmt   = FMT_I;
                use_rs1   = 1'b1;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000: dec_op = LB;
                    3'b001: dec_op = LH;
                    3'b010: dec_op = LW;
                    3'b100: dec_op = LBU;
                    3'b101: dec_op = LHU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec_fmt   = FMT_S;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000: dec_op = SB;
                    3'b001: dec_op = SH;
                    3'b010: dec_op = SW;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                dec_fmt   = FMT_B;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000: dec_op = BEQ;
                    3'b001: dec_op = BNE;
                    3'b100: dec_op = BLT;
                    3'b101: dec_op = BGE;
                    3'b110: dec_op = BLTU;
                    3'b111: dec_op = BGEU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LUI:   begin dec_fmt = FMT_U; dec_op = LUI;   dec_legal = 1'b1; end
            OPC_AUIPC: begin dec_fmt = FMT_U; dec_op = AUIPC; dec_legal = 1'b1; end
            OPC_JAL:   begin dec_fmt = FMT_J; dec_op = JAL;   dec_legal = 1'b1; end
            OPC_JALR: begin
                dec_fmt   = FMT_I;
                dec_op    = JALR;
                use_rs1   = 1'b1;
                dec_legal = (funct3 == 3'b000);
            end
            default: dec_legal = 1'b0;
        endcase
        if (in_inst[1:0] != 2'b11) begin
            dec_legal = 1'b0;
        end
        if (!dec_legal) begin
            dec_op = NOP;
        end
    end

    imm_gen u_imm_gen (
        .inst (in_inst),
        .fmt  (dec_fmt),
        .imm  (dec_imm)
    );

    always_comb begin
        dec_entry.op      = dec_op;
        dec_entry.fmt     = dec_fmt;
        dec_entry.rd      = in_inst[11:7];
        dec_entry.rs1     = use_rs1 ? in_inst[19:15] : 5'd0;
        dec_entry.rs2     = use_rs2 ? in_inst[24:20] : 5'd0;
        dec_entry.rd_we   = dec_legal && (dec_fmt != FMT_S) && (dec_fmt != FMT_B)
                            && (in_inst[11:7] != 5'd0);
        dec_entry.imm     = dec_imm;
        dec_entry.pc      = in_pc;
        dec_entry.illegal = !dec_legal;
    end

    assign in_ready  = (state_reg != TWO) && !reset;
    assign out_valid = (state_reg != EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= EMPTY;
            head_reg  <= ENTRY_RESET;
            tail_reg  <= ENTRY_RESET;
        end else if (flush) begin
            state_reg <= EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (push) begin
                    head_reg  <= dec_entry;
                    state_reg <= ONE;
                end
                ONE: begin
                    if (push && pop) begin
                        head_reg <= dec_entry;
                    end else if (push) begin
                        tail_reg  <= dec_entry;
                        state_reg <= TWO;
                    end else if (pop) begin
                        state_reg <= EMPTY;
                    end
                end
                TWO: if (pop) begin
                    head_reg  <= tail_reg;
                    state_reg <= ONE;
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign out_alu_op  = head_reg.op;
    assign out_fmt     = head_reg.fmt;
    assign out_rd      = head_reg.rd;
    assign out_rs1     = head_reg.rs1;
    assign out_rs2     = head_reg.rs2;
    assign out_rd_we   = head_reg.rd_we;
    assign out_imm     = head_reg.imm;
    assign out_pc      = head_reg.pc;
    assign out_illegal = head_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Random + directed bench for decode_stage, checking both ENABLE_M builds against a rule-table model.
module tb_decode_stage;
    import rv_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready [2];
    logic        out_valid [2];
    alu_op_t     out_alu_op [2];
    inst_fmt_t   out_fmt [2];
    logic [4:0]  out_rd [2], out_rs1 [2], out_rs2 [2];
    logic        out_rd_we [2], out_illegal [2];
    logic [31:0] out_imm [2], out_pc [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            decode_stage #(.ENABLE_M(gi), .PC_W(32)) dut (
                .clock(clock), .reset(reset), .flush(flush),
                .in_valid(in_valid), .in_ready(in_ready[gi]),
                .in_inst(in_inst), .in_pc(in_pc),
                .out_valid(out_valid[gi]), .out_ready(out_ready),
                .out_alu_op(out_alu_op[gi]), .out_fmt(out_fmt[gi]),
                .out_rd(out_rd[gi]), .out_rs1(out_rs1[gi]), .out_rs2(out_rs2[gi]),
                .out_rd_we(out_rd_we[gi]), .out_imm(out_imm[gi]),
                .out_pc(out_pc[gi]), .out_illegal(out_illegal[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        bit         f3_any;
        logic [6:0] f7;
        bit         f7_any;
        alu_op_t    op;
        inst_fmt_t  fmt;
        bit         needs_m;
    } rule_t;

    typedef struct {
        alu_op_t     op;
        inst_fmt_t   fmt;
        logic [4:0]  rd, rs1, rs2;
        logic        rd_we;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } txn_t;

    rule_t rules [$];
    txn_t  sb [$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    n_acc = 0;
    bit    zero_flag = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic add_rule(input logic [6:0] opc, input logic [2:0] f3, input bit f3_any,
                            input logic [6:0] f7, input bit f7_any, input alu_op_t op,
                            input inst_fmt_t fmt, input bit needs_m);
        rule_t r;
        r.opc = opc; r.f3 = f3; r.f3_any = f3_any; r.f7 = f7; r.f7_any = f7_any;
        r.op = op; r.fmt = fmt; r.needs_m = needs_m;
        rules.push_back(r);
    endtask

    task automatic build_rules();
        alu_op_t base [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        alu_op_t mops [8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
        alu_op_t iops [6] = '{ADDI, SLTI, SLTIU, XORI, ORI, ANDI};
        logic [2:0] if3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        alu_op_t lops [5] = '{LB, LH, LW, LBU, LHU};
        logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        alu_op_t bops [6] = '{BEQ, BNE, BLT, BGE, BLTU, BGEU};
        logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int k = 0; k < 8; k++) begin
            add_rule(7'b0110011, 3'(k), 0, 7'b0000000, 0, base[k], FMT_R, 0);
            add_rule(7'b0110011, 3'(k), 0, 7'b0000001, 0, mops[k], FMT_R, 1);
        end
        add_rule(7'b0110011, 3'd0, 0, 7'b0100000, 0, SUB, FMT_R, 0);
        add_rule(7'b0110011, 3'd5, 0, 7'b0100000, 0, SRA, FMT_R, 0);
        for (int k = 0; k < 6; k++) add_rule(7'b0010011, if3[k], 0, 7'd0, 1, iops[k], FMT_I, 0);
        add_rule(7'b0010011, 3'd1, 0, 7'b0000000, 0, SLLI, FMT_I, 0);
        add_rule(7'b0010011, 3'd5, 0, 7'b0000000, 0, SRLI, FMT_I, 0);
        add_rule(7'b0010011, 3'd5, 0, 7'b0100000, 0, SRAI, FMT_I, 0);
        for (int k = 0; k < 5; k++) add_rule(7'b0000011, lf3[k], 0, 7'd0, 1, lops[k], FMT_I, 0);
        add_rule(7'b0100011, 3'd0, 0, 7'd0, 1, SB, FMT_S, 0);
        add_rule(7'b0100011, 3'd1, 0, 7'd0, 1, SH, FMT_S, 0);
        add_rule(7'b0100011, 3'd2, 0, 7'd0, 1, SW, FMT_S, 0);
        for (int k = 0; k < 6; k++) add_rule(7'b1100011, bf3[k], 0, 7'd0, 1, bops[k], FMT_B, 0);
        add_rule(7'b0110111, 3'd0, 1, 7'd0, 1, LUI, FMT_U, 0);
        add_rule(7'b0010111, 3'd0, 1, 7'd0, 1, AUIPC, FMT_U, 0);
        add_rule(7'b1101111, 3'd0, 1, 7'd0, 1, JAL, FMT_J, 0);
        add_rule(7'b1100111, 3'd0, 0, 7'd0, 1, JALR, FMT_I, 0);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i, input bit m);
        exp_t  e;
        rule_t r;
        bit    found = 0;
        foreach (rules[k]) begin
            if (!found && rules[k].opc == i[6:0] && (rules[k].f3_any || rules[k].f3 == i[14:12])
                && (rules[k].f7_any || rules[k].f7 == i[31:25])) begin
                found = 1;
                r = rules[k];
            end
        end
        e.illegal = !(found && i[1:0] == 2'b11 && (!r.needs_m || m));
        e.op  = e.illegal ? NOP : r.op;
        e.fmt = r.fmt;
        e.rd  = i[11:7];
        e.rs1 = (r.fmt == FMT_U || r.fmt == FMT_J) ? 5'd0 : i[19:15];
        e.rs2 = (r.fmt == FMT_R || r.fmt == FMT_S || r.fmt == FMT_B) ? i[24:20] : 5'd0;
        e.rd_we = !e.illegal && (r.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && i[11:7] != 0;
        case (r.fmt)
            FMT_I: e.imm = {{20{i[31]}}, i[31:20]};
            FMT_S: e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B: e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U: e.imm = {i[31:12], 12'd0};
            FMT_J: e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        rule_t r;
        i = $urandom;
        if ($urandom_range(7) == 0) return i;
        r = rules[$urandom_range(rules.size() - 1)];
        i[6:0] = r.opc;
        if (!r.f3_any) i[14:12] = r.f3;
        if (!r.f7_any) i[31:25] = r.f7;
        if ($urandom_range(15) == 0) i[11:7] = 5'd0;
        return i;
    endfunction

    task automatic check_head(input int d, input txn_t t);
        exp_t e = ref_decode(t.inst, d == 1);
        check($sformatf("d%0d_illegal[%08h]", d, t.inst), out_illegal[d], e.illegal);
        check($sformatf("d%0d_op[%08h]", d, t.inst), out_alu_op[d], e.op);
        check($sformatf("d%0d_rd_we[%08h]", d, t.inst), out_rd_we[d], e.rd_we);
        check($sformatf("d%0d_pc[%08h]", d, t.inst), out_pc[d], t.pc);
        if (!e.illegal) begin
            check($sformatf("d%0d_fmt[%08h]", d, t.inst), out_fmt[d], e.fmt);
            check($sformatf("d%0d_rd[%08h]", d, t.inst), out_rd[d], e.rd);
            check($sformatf("d%0d_rs1[%08h]", d, t.inst), out_rs1[d], e.rs1);
            check($sformatf("d%0d_rs2[%08h]", d, t.inst), out_rs2[d], e.rs2);
            check($sformatf("d%0d_imm[%08h]", d, t.inst), out_imm[d], e.imm);
        end
    endtask

    task automatic check_zero(input int d);
        check($sformatf("d%0d_rst_op", d), out_alu_op[d], NOP);
        check($sformatf("d%0d_rst_fields", d),
              {out_fmt[d], out_rd[d], out_rs1[d], out_rs2[d], out_rd_we[d], out_illegal[d]}, 0);
        check($sformatf("d%0d_rst_imm_pc", d), {out_imm[d], out_pc[d]}, 0);
    endtask

    task automatic cycle(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                         input bit ordy, input bit fl, input bit rst);
        int  cnt;
        bit  exp_rdy, do_pop, do_push;
        txn_t t;
        @(negedge clock);
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; reset = rst;
        #1;
        cnt = sb.size();
        exp_rdy = (cnt < 2) && !rst;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_in_ready", d), in_ready[d], exp_rdy);
            check($sformatf("d%0d_out_valid", d), out_valid[d], cnt > 0);
            if (cnt > 0) check_head(d, sb[0]);
            else if (zero_flag) check_zero(d);
        end
        if (in_valid && in_ready[0]) n_acc++;
        do_pop  = (cnt > 0) && ordy;
        do_push = iv && exp_rdy && !fl;
        if (rst || fl) begin
            sb.delete();
            if (rst) zero_flag = 1'b1;
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                t.inst = inst;
                t.pc = pc;
                sb.push_back(t);
                zero_flag = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 32'd0, 32'd0, ordy, 0, 0);
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_inst = 0; in_pc = 0;
        build_rules();
        repeat (2) @(posedge clock);

        idle(1);

        cycle(1, 32'h00B50533, 32'h0000_1000, 1, 0, 0);
        idle(1);
        check("add_valid", out_valid[0], 1);
        check("add_op", out_alu_op[0], ADD);
        check("add_fmt", out_fmt[0], FMT_R);
        check("add_regs", {out_rd[0], out_rs1[0], out_rs2[0]}, {5'd10, 5'd10, 5'd11});
        check("add_we_ill", {out_rd_we[0], out_illegal[0]}, 2'b10);

        cycle(1, 32'h40B50533, 32'h0000_1004, 1, 0, 0);
        idle(1);
        check("sub_op", out_alu_op[0], SUB);

        cycle(1, 32'hFFF00093, 32'h0000_1008, 1, 0, 0);
        idle(1);
        check("addi_op", out_alu_op[0], ADDI);
        check("addi_regs", {out_rd[0], out_rs1[0]}, {5'd1, 5'd0});
        check("addi_imm", out_imm[0], 32'hFFFF_FFFF);

        cycle(1, 32'h02B50533, 32'h0000_100C, 1, 0, 0);
        idle(1);
        check("mul_m0", {out_illegal[0], out_rd_we[0]}, 2'b10);
        check("mul_m0_op", out_alu_op[0], NOP);
        check("mul_m1_op", out_alu_op[1], MUL);
        check("mul_m1_ill", out_illegal[1], 0);

        n_acc = 0;
        for (int k = 0; k < 4; k++) cycle(1, 32'h00000013 | (32'(k + 1) << 7), 32'h200 + 32'(k), 0, 0, 0);
        check("stall_accepted", n_acc, 2);
        repeat (3) idle(1);

        cycle(1, 32'h00100093, 32'h300, 0, 0, 0);
        cycle(1, 32'h00200113, 32'h304, 0, 0, 0);
        cycle(1, 32'h00300193, 32'h308, 0, 1, 0);
        idle(0);
        check("flush_valid", out_valid[0], 0);
        check("flush_ready", in_ready[0], 1);
        idle(1);

        cycle(1, 32'h00B50533, 32'h400, 0, 0, 0);
        cycle(0, 32'd0, 32'd0, 0, 0, 1);
        idle(0);
        check("rst_valid", out_valid[0], 0);
        check("rst_ready", in_ready[0], 1);
        check("rst_op", out_alu_op[0], NOP);
        cycle(1, 32'hFFF00093, 32'h404, 1, 0, 0);
        idle(1);
        check("post_rst_op", out_alu_op[0], ADDI);

        for (int k = 0; k < 4000; k++) begin
            cycle($urandom_range(3) != 0, rand_inst(), $urandom, $urandom_range(2) != 0,
                  $urandom_range(24) == 0, $urandom_range(99) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
